fetch_queue: RTL

Instruction fetch queue between the IFU and the decode/control stage. Captures each fetched {pc, instruction} pair into a small register-array FIFO and presents the oldest entry to decode through a valid/ready handshake. This decouples fetch from decode stalls and discards all wrong-path instructions when a branch or jump redirect is signalled.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 79 +++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types used by the fetch path.
package cpu_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0]    RESET_PC  = 32'h0000_3000;

  typedef struct packed {
    logic               misalign;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue: register-array FIFO of {pc, instr} between IFU and decode,
// with a redirect flush that discards all wrong-path entries.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_misalign,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic      w_push;
  logic      w_pop;
  fq_entry_t w_new;
  fq_entry_t w_head;

  // Occupancy is its own register so full and empty never alias when pointers match.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  always_comb begin
    w_new          = '0;
    w_new.misalign = pc_misaligned(in_pc);
    w_new.pc       = in_pc;
    w_new.instr    = in_instr;
  end

  assign w_head = r_mem[r_rd_ptr];

  // Empty queue presents a nop at PC 0 so decode never sees stale contents.
  assign out_pc       = out_valid ? w_head.pc    : '0;
  assign out_instr    = out_valid ? w_head.instr : NOP_INSTR;
  assign out_misalign = out_valid & w_head.misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new;
  end

endmodule
